// File: rtl/unidade_controle.sv
// Multicycle control sequencer for the Nano MIPS datapath: walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB and issues registered, single-cycle strobes.
module unidade_controle #(
  parameter int             OPW    = 4,
  parameter logic [OPW-1:0] OP_HLT = OPW'(4'hF)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           pausa,
  output logic           ld_pc,
  output logic           ld_ir,
  output logic           ld_a,
  output logic           ld_b,
  output logic           ld_acc,
  output logic           ld_mar,
  output logic           ld_mdr,
  output logic           ld_rd,
  output logic           sel_pc,
  output logic [1:0]     alu_op,
  output logic [1:0]     sel_wb,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic           halted,
  output logic [2:0]     estado
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB = OPW'(2);
  localparam logic [OPW-1:0] OP_AND = OPW'(3);
  localparam logic [OPW-1:0] OP_OR  = OPW'(4);
  localparam logic [OPW-1:0] OP_LI  = OPW'(5);
  localparam logic [OPW-1:0] OP_LW  = OPW'(6);
  localparam logic [OPW-1:0] OP_SW  = OPW'(7);
  localparam logic [OPW-1:0] OP_BEQ = OPW'(8);
  localparam logic [OPW-1:0] OP_JMP = OPW'(9);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_HALT   = 3'b101
  } state_t;

  typedef struct packed {
    logic       ld_pc;
    logic       ld_ir;
    logic       ld_a;
    logic       ld_b;
    logic       ld_acc;
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_rd;
    logic       sel_pc;
    logic [1:0] alu_op;
    logic [1:0] sel_wb;
    logic       mem_rd;
    logic       mem_wr;
  } ctl_t;

  state_t         state_q, state_d;
  ctl_t           ctl_q, ctl_d;
  logic [OPW-1:0] op_q, op_d;
  logic           zero_q, zero_d;
  logic           pend_q, pend_d;
  logic           halted_q, halted_d;
  logic           hold;

  always_comb begin
    // pend_q marks a state whose outputs still owe one issue (after reset or a stall)
    hold     = pausa | pend_q;
    state_d  = state_q;
    op_d     = op_q;
    zero_d   = zero_q;
    pend_d   = pausa;
    ctl_d    = '0;
    halted_d = 1'b0;

    if (!hold) begin
      case (state_q)
        S_FETCH: state_d = S_DECODE;
        S_DECODE: begin
          op_d = opcode;
          if (opcode == OP_HLT) begin
            state_d = S_HALT;
          end else begin
            case (opcode)
              OP_ADD, OP_SUB, OP_AND, OP_OR,
              OP_LW, OP_SW, OP_BEQ, OP_JMP: state_d = S_EXEC;
              OP_LI:                        state_d = S_WB;
              default:                      state_d = S_FETCH;
            endcase
          end
        end
        S_EXEC: begin
          zero_d = zero;
          case (op_q)
            OP_LW, OP_SW: state_d = S_MEM;
            OP_JMP:       state_d = S_FETCH;
            default:      state_d = S_WB;
          endcase
        end
        S_MEM:   state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        S_WB:    state_d = S_FETCH;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end

    halted_d = (state_d == S_HALT);

    // Outputs are decoded from the state being entered so they line up with estado
    if (!pausa) begin
      case (state_d)
        S_FETCH: begin
          ctl_d.ld_ir = 1'b1;
          ctl_d.ld_pc = 1'b1;
        end
        S_DECODE: begin
          ctl_d.ld_a = 1'b1;
          ctl_d.ld_b = 1'b1;
        end
        S_EXEC: begin
          case (op_d)
            OP_ADD: begin ctl_d.ld_acc = 1'b1; ctl_d.alu_op = 2'b00; end
            OP_SUB: begin ctl_d.ld_acc = 1'b1; ctl_d.alu_op = 2'b01; end
            OP_AND: begin ctl_d.ld_acc = 1'b1; ctl_d.alu_op = 2'b10; end
            OP_OR:  begin ctl_d.ld_acc = 1'b1; ctl_d.alu_op = 2'b11; end
            OP_LW, OP_SW: ctl_d.ld_mar = 1'b1;
            OP_BEQ: ctl_d.alu_op = 2'b01;
            OP_JMP: begin ctl_d.ld_pc = 1'b1; ctl_d.sel_pc = 1'b1; end
            default: ;
          endcase
        end
        S_MEM: begin
          if (op_d == OP_LW) begin
            ctl_d.mem_rd = 1'b1;
            ctl_d.ld_mdr = 1'b1;
          end else if (op_d == OP_SW) begin
            ctl_d.mem_wr = 1'b1;
          end
        end
        S_WB: begin
          case (op_d)
            OP_ADD, OP_SUB, OP_AND, OP_OR: ctl_d.ld_rd = 1'b1;
            OP_LW: begin ctl_d.ld_rd = 1'b1; ctl_d.sel_wb = 2'b01; end
            OP_LI: begin ctl_d.ld_rd = 1'b1; ctl_d.sel_wb = 2'b10; end
            OP_BEQ: begin ctl_d.ld_pc = zero_d; ctl_d.sel_pc = 1'b1; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      ctl_q    <= '0;
      op_q     <= '0;
      zero_q   <= 1'b0;
      pend_q   <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctl_q    <= ctl_d;
      op_q     <= op_d;
      zero_q   <= zero_d;
      pend_q   <= pend_d;
      halted_q <= halted_d;
    end
  end

  assign ld_pc  = ctl_q.ld_pc;
  assign ld_ir  = ctl_q.ld_ir;
  assign ld_a   = ctl_q.ld_a;
  assign ld_b   = ctl_q.ld_b;
  assign ld_acc = ctl_q.ld_acc;
  assign ld_mar = ctl_q.ld_mar;
  assign ld_mdr = ctl_q.ld_mdr;
  assign ld_rd  = ctl_q.ld_rd;
  assign sel_pc = ctl_q.sel_pc;
  assign alu_op = ctl_q.alu_op;
  assign sel_wb = ctl_q.sel_wb;
  assign mem_rd = ctl_q.mem_rd;
  assign mem_wr = ctl_q.mem_wr;
  assign halted = halted_q;
  assign estado = state_q;

endmodule
